// File: rtl/pipe_stage_skid_if.sv
// Valid/ready channel carrying a payload and a control field between pipeline stages.
interface pipe_stage_skid_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 12
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a 1-entry skid buffer and flush-to-bubble.
// Optional perf counters (stall_cnt, flush_cnt) are built when PIPE_PERF_CNT_EN is defined.
module pipe_stage_skid #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       CTRL_W      = 12,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
  parameter int unsigned       CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_stage_skid_if.slave  up,
  pipe_stage_skid_if.master dn
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  logic              m_v_q, m_v_d, s_v_q, s_v_d;
  logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic              in_ready_q, in_ready_d;
  logic              accept, drain;

  assign accept = up.valid & in_ready_q;
  assign drain  = m_v_q & dn.ready;

  always_comb begin
    m_v_d    = m_v_q;
    m_data_d = m_data_q;
    m_ctrl_d = m_ctrl_q;
    s_v_d    = s_v_q;
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_q;
    if (flush) begin
      m_v_d    = 1'b0;
      m_data_d = '0;
      m_ctrl_d = BUBBLE_CTRL;
      s_v_d    = 1'b0;
      s_data_d = '0;
      s_ctrl_d = BUBBLE_CTRL;
    end else if (!m_v_q || drain) begin
      if (s_v_q) begin
        m_v_d    = 1'b1;
        m_data_d = s_data_q;
        m_ctrl_d = s_ctrl_q;
        s_v_d    = 1'b0;
        s_data_d = '0;
        s_ctrl_d = BUBBLE_CTRL;
      end else if (accept) begin
        m_v_d    = 1'b1;
        m_data_d = up.data;
        m_ctrl_d = up.ctrl;
      end else begin
        // Main regs double as outputs, so an empty stage must hold the bubble encoding.
        m_v_d    = 1'b0;
        m_data_d = '0;
        m_ctrl_d = BUBBLE_CTRL;
      end
    end else if (accept) begin
      s_v_d    = 1'b1;
      s_data_d = up.data;
      s_ctrl_d = up.ctrl;
    end
    in_ready_d = ~s_v_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_v_q      <= 1'b0;
      m_data_q   <= '0;
      m_ctrl_q   <= BUBBLE_CTRL;
      s_v_q      <= 1'b0;
      s_data_q   <= '0;
      s_ctrl_q   <= BUBBLE_CTRL;
      in_ready_q <= 1'b1;
    end else begin
      m_v_q      <= m_v_d;
      m_data_q   <= m_data_d;
      m_ctrl_q   <= m_ctrl_d;
      s_v_q      <= s_v_d;
      s_data_q   <= s_data_d;
      s_ctrl_q   <= s_ctrl_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign up.ready = in_ready_q;
  assign dn.valid = m_v_q;
  assign dn.data  = m_data_q;
  assign dn.ctrl  = m_ctrl_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W:0]   flush_sum;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_v_q && !dn.ready && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    // One bit of headroom so adding two killed entries saturates cleanly.
    flush_sum   = {1'b0, flush_cnt_q} + {{CNT_W{1'b0}}, m_v_q} + {{CNT_W{1'b0}}, s_v_q};
    flush_cnt_d = flush_cnt_q;
    if (flush) begin
      flush_cnt_d = flush_sum[CNT_W] ? {CNT_W{1'b1}} : flush_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed, table-driven bench for pipe_stage_skid; perf checks build with PIPE_PERF_CNT_EN.
module tb_pipe_stage_skid;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 12;
  localparam int unsigned CNT_W  = 4;
  // Non-zero bubble so a stage that clears ctrl to 0 instead of BUBBLE_CTRL is caught.
  localparam logic [CTRL_W-1:0] BUB = 12'h3C0;

  logic clk = 1'b0;
  logic rst, flush;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) up_if ();
  pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dn_if ();

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  pipe_stage_skid #(
    .DATA_W     (DATA_W),
    .CTRL_W     (CTRL_W),
    .BUBBLE_CTRL(BUB),
    .CNT_W      (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .up       (up_if.slave),
    .dn       (dn_if.master)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  typedef struct {
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        fl;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_ready;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Entry control is derived from data so ctrl routing is checked alongside payload.
  function automatic logic [CTRL_W-1:0] ctrl_of(input logic [31:0] d);
    return CTRL_W'(12'h800 | d[7:0]);
  endfunction

  task automatic drive(input logic v, input logic [31:0] d, input logic ordy, input logic fl);
    up_if.valid = v;
    up_if.data  = d;
    up_if.ctrl  = ctrl_of(d);
    dn_if.ready = ordy;
    flush       = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic ev, input logic [31:0] ed,
                               input logic er);
    check({tag, ".out_valid"}, 32'(dn_if.valid), 32'(ev));
    check({tag, ".out_data"}, dn_if.data, ev ? ed : 32'h0);
    check({tag, ".out_ctrl"}, 32'(dn_if.ctrl), ev ? 32'(ctrl_of(ed)) : 32'(BUB));
    check({tag, ".in_ready"}, 32'(up_if.ready), 32'(er));
  endtask

  initial begin
    //          in_v  data   ordy  fl    exp_v exp_d  exp_rdy
    vecs[0]  = '{1'b1, 32'h1, 1'b1, 1'b0, 1'b1, 32'h1, 1'b1};
    vecs[1]  = '{1'b1, 32'h2, 1'b1, 1'b0, 1'b1, 32'h2, 1'b1};
    vecs[2]  = '{1'b1, 32'h3, 1'b1, 1'b0, 1'b1, 32'h3, 1'b1};
    vecs[3]  = '{1'b1, 32'h4, 1'b1, 1'b0, 1'b1, 32'h4, 1'b1};
    vecs[4]  = '{1'b0, 32'h9, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1};
    vecs[5]  = '{1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 32'hA, 1'b1};
    vecs[6]  = '{1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 32'hA, 1'b0};
    vecs[7]  = '{1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 32'hA, 1'b0};
    vecs[8]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hB, 1'b1};
    vecs[9]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1};
    vecs[10] = '{1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 32'hA, 1'b1};
    vecs[11] = '{1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 32'hA, 1'b0};
    vecs[12] = '{1'b1, 32'hC, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1};
    vecs[13] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1};
    vecs[14] = '{1'b1, 32'hD, 1'b0, 1'b0, 1'b1, 32'hD, 1'b1};
    vecs[15] = '{1'b1, 32'hE, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1};
    vecs[16] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1};

    // Reset held two cycles with in_valid high.
    rst = 1'b1;
    drive(1'b1, 32'h55, 1'b1, 1'b0);
    check_outputs("reset1", 1'b0, 32'h0, 1'b1);
    drive(1'b1, 32'h66, 1'b1, 1'b0);
    check_outputs("reset2", 1'b0, 32'h0, 1'b1);
`ifdef PIPE_PERF_CNT_EN
    check("reset.stall_cnt", 32'(stall_cnt), 32'h0);
    check("reset.flush_cnt", 32'(flush_cnt), 32'h0);
`endif
    rst = 1'b0;

    // Streaming, backpressure with skid, flush with full stage, flush with accept+drain.
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready, vecs[i].fl);
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                    vecs[i].exp_ready);
    end
`ifdef PIPE_PERF_CNT_EN
    // Stalls at vectors 6, 7, 11; flushes kill 2 (vec 12) and 1 (vec 15).
    check("table.stall_cnt", 32'(stall_cnt), 32'd3);
    check("table.flush_cnt", 32'(flush_cnt), 32'd3);
`endif

    // Reset mid-operation with a full stage.
    drive(1'b1, 32'h21, 1'b0, 1'b0);
    drive(1'b1, 32'h22, 1'b0, 1'b0);
    check_outputs("full", 1'b1, 32'h21, 1'b0);
    rst = 1'b1;
    drive(1'b1, 32'h23, 1'b0, 1'b0);
    check_outputs("midrst", 1'b0, 32'h0, 1'b1);
`ifdef PIPE_PERF_CNT_EN
    check("midrst.stall_cnt", 32'(stall_cnt), 32'h0);
    check("midrst.flush_cnt", 32'(flush_cnt), 32'h0);
`endif
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check_outputs("postrst", 1'b0, 32'h0, 1'b1);

    // Stall counting and saturation with a held entry.
    drive(1'b1, 32'h31, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0);
    end
    check_outputs("stall_hold", 1'b1, 32'h31, 1'b1);
`ifdef PIPE_PERF_CNT_EN
    check("stall5.stall_cnt", 32'(stall_cnt), 32'd5);
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0);
    end
    check("stall_sat.stall_cnt", 32'(stall_cnt), 32'(4'hF));
    // Fill skid, then flush twice more to push flush_cnt (0) -> 2 -> ... to saturation.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h40, 1'b0, 1'b0);
      drive(1'b1, 32'h41, 1'b0, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 1'b1);
    end
    check("flush_sat.flush_cnt", 32'(flush_cnt), 32'(4'hF));
    check("flush_sat.stall_cnt", 32'(stall_cnt), 32'(4'hF));
`endif
    drive(1'b0, 32'h0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
